// File: rtl/prog_mod_counter.sv
// Programmable modulo up/down counter with optional one-shot stop at terminal count.
// Latency: Q and halted are registered (1 cycle); done and tick are combinational from Q/state/inputs.
// Backpressure: none; enable gates counting, load overrides everything except reset.
module prog_mod_counter #(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            up,
  input  logic            load,
  input  logic [BITS-1:0] load_value,
  input  logic [BITS-1:0] FINAL_VALUE,
  input  logic            one_shot,
  output logic [BITS-1:0] Q,
  output logic            done,
  output logic            tick,
  output logic            halted
);

  typedef enum logic {
    COUNT = 1'b0,
    HALT  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [BITS-1:0] q_nxt;

  // Terminal count: counting up, anything at or above the limit is terminal so an
  // out-of-range value wraps instead of running through the full 2^BITS space.
  always_comb begin
    done = up ? (Q >= FINAL_VALUE) : (Q == '0);
  end

  // Cascade pulse: only while actually counting, and never on a load edge.
  always_comb begin
    tick = enable & done & (state == COUNT) & ~load;
  end

  always_comb begin
    halted = (state == HALT);
  end

  // Next-state / next-count: load, then HALT hold, then enabled counting, else hold.
  always_comb begin
    state_nxt = state;
    q_nxt     = Q;
    if (load) begin
      q_nxt     = load_value;
      state_nxt = COUNT;
    end else if (state == HALT) begin
      // Leaving HALT by dropping one_shot does not move Q on that edge.
      if (!one_shot) begin
        state_nxt = COUNT;
      end
    end else if (enable) begin
      if (done) begin
        if (one_shot) begin
          state_nxt = HALT;
        end else begin
          q_nxt = up ? '0 : FINAL_VALUE;
        end
      end else begin
        q_nxt = up ? (Q + BITS'(1)) : (Q - BITS'(1));
      end
    end
  end

  // State and count registers with synchronous reset taking precedence over all else.
  always_ff @(posedge clk) begin
    if (reset) begin
      Q     <= '0;
      state <= COUNT;
    end else begin
      Q     <= q_nxt;
      state <= state_nxt;
    end
  end

endmodule

// File: tb/tb_prog_mod_counter.sv
module tb_prog_mod_counter;
  localparam int BITS = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            up;
  logic            load;
  logic            one_shot;
  logic [BITS-1:0] load_value;
  logic [BITS-1:0] final_value;
  logic [BITS-1:0] q;
  logic            done;
  logic            tick;
  logic            halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prog_mod_counter #(.BITS(BITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .FINAL_VALUE(final_value),
    .one_shot   (one_shot),
    .Q          (q),
    .done       (done),
    .tick       (tick),
    .halted     (halted)
  );

  // Advance one clock; inputs are driven and outputs sampled 2-3 time units after the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load = 1'b0;
    enable = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL reset_init_q got %0d want 0", q); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_init_halted got %b want 0", halted); end
    // Reach Q=7 in HALT.
    load_value = 4'd7; final_value = 4'd7; up = 1'b1; one_shot = 1'b1; enable = 1'b1; load = 1'b1;
    cyc();
    load = 1'b0;
    #1;
    checks++; if (q !== 4'd7) begin errors++; $display("FAIL reset_setup_q got %0d want 7", q); end
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL reset_setup_tick got %b want 1", tick); end
    cyc();
    #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL reset_setup_halted got %b want 1", halted); end
    checks++; if (q !== 4'd7) begin errors++; $display("FAIL reset_setup_hold got %0d want 7", q); end
    // Reset overrides load and enable.
    reset = 1'b1; load = 1'b1; load_value = 4'd3;
    cyc();
    reset = 1'b0; load = 1'b0; enable = 1'b0;
    #1;
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL reset_q got %0d want 0", q); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  task automatic test_up_wrap();
    logic [BITS-1:0] exp;
    do_reset();
    final_value = 4'd9; up = 1'b1; one_shot = 1'b0; enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp = BITS'(i % 10);
      #1;
      checks++; if (q !== exp) begin errors++; $display("FAIL up_wrap_q step %0d got %0d want %0d", i, q, exp); end
      checks++; if (tick !== (exp == 4'd9)) begin errors++; $display("FAIL up_wrap_tick step %0d got %b want %b", i, tick, (exp == 4'd9)); end
      cyc();
    end
  endtask

  task automatic test_down_wrap();
    int seq[8] = '{0, 5, 4, 3, 2, 1, 0, 5};
    do_reset();
    final_value = 4'd5; up = 1'b0; one_shot = 1'b0; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (q !== BITS'(seq[i])) begin errors++; $display("FAIL down_wrap_q step %0d got %0d want %0d", i, q, seq[i]); end
      checks++; if (tick !== (seq[i] == 0)) begin errors++; $display("FAIL down_wrap_tick step %0d got %b want %b", i, tick, (seq[i] == 0)); end
      cyc();
    end
  endtask

  task automatic test_one_shot();
    int seq[6] = '{0, 1, 2, 3, 3, 3};
    do_reset();
    final_value = 4'd3; up = 1'b1; one_shot = 1'b1; enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (q !== BITS'(seq[k])) begin errors++; $display("FAIL one_shot_q step %0d got %0d want %0d", k, q, seq[k]); end
      checks++; if (halted !== (k >= 4)) begin errors++; $display("FAIL one_shot_halted step %0d got %b want %b", k, halted, (k >= 4)); end
      checks++; if (tick !== (k == 3)) begin errors++; $display("FAIL one_shot_tick step %0d got %b want %b", k, tick, (k == 3)); end
      cyc();
    end
    load = 1'b1; load_value = 4'd1;
    #1;
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL one_shot_load_tick got %b want 0", tick); end
    cyc();
    load = 1'b0;
    #1;
    checks++; if (q !== 4'd1) begin errors++; $display("FAIL one_shot_reload_q got %0d want 1", q); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL one_shot_reload_halted got %b want 0", halted); end
  endtask

  task automatic test_halt_exit();
    do_reset();
    final_value = 4'd2; up = 1'b1; one_shot = 1'b1; enable = 1'b1;
    repeat (4) cyc();
    #1;
    checks++; if (q !== 4'd2) begin errors++; $display("FAIL halt_q got %0d want 2", q); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_halted got %b want 1", halted); end
    // Direction change while halted must not move Q.
    up = 1'b0;
    cyc();
    #1;
    checks++; if (q !== 4'd2) begin errors++; $display("FAIL halt_down_hold got %0d want 2", q); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL halt_tick got %b want 0", tick); end
    one_shot = 1'b0;
    cyc();
    #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_exit_halted got %b want 0", halted); end
    checks++; if (q !== 4'd2) begin errors++; $display("FAIL halt_exit_q got %0d want 2", q); end
    cyc();
    #1;
    checks++; if (q !== 4'd1) begin errors++; $display("FAIL halt_exit_count got %0d want 1", q); end
  endtask

  task automatic test_out_of_range();
    int seq[5] = '{12, 11, 10, 9, 8};
    do_reset();
    final_value = 4'd9; up = 1'b1; one_shot = 1'b0; load = 1'b1; load_value = 4'd12;
    cyc();
    load = 1'b0; enable = 1'b1;
    #1;
    checks++; if (q !== 4'd12) begin errors++; $display("FAIL oor_load_q got %0d want 12", q); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL oor_done got %b want 1", done); end
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL oor_tick got %b want 1", tick); end
    cyc();
    #1;
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL oor_wrap_q got %0d want 0", q); end
    load = 1'b1; up = 1'b0;
    cyc();
    load = 1'b0;
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL oor_down_done got %b want 0", done); end
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (q !== BITS'(seq[i])) begin errors++; $display("FAIL oor_down_q step %0d got %0d want %0d", i, q, seq[i]); end
      cyc();
    end
  endtask

  task automatic test_hold_priority();
    up = 1'b1; final_value = 4'd9; one_shot = 1'b0;
    load = 1'b1; load_value = 4'd4; enable = 1'b0;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (q !== 4'd4) begin errors++; $display("FAIL hold_q step %0d got %0d want 4", i, q); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL hold_tick step %0d got %b want 0", i, tick); end
      cyc();
    end
    #1;
    checks++; if (q !== 4'd4) begin errors++; $display("FAIL hold_final_q got %0d want 4", q); end
    load = 1'b1; enable = 1'b1; load_value = 4'd2;
    cyc();
    load = 1'b0; enable = 1'b0;
    #1;
    checks++; if (q !== 4'd2) begin errors++; $display("FAIL priority_q got %0d want 2", q); end
  endtask

  task automatic test_final_zero();
    do_reset();
    final_value = 4'd0; up = 1'b1; one_shot = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (q !== 4'd0) begin errors++; $display("FAIL zero_q step %0d got %0d want 0", i, q); end
      checks++; if (tick !== 1'b1) begin errors++; $display("FAIL zero_tick step %0d got %b want 1", i, tick); end
      cyc();
    end
    enable = 1'b0;
    #1;
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL zero_tick_off got %b want 0", tick); end
    enable = 1'b1; up = 1'b0;
    cyc();
    #1;
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL zero_down_q got %0d want 0", q); end
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL zero_down_tick got %b want 1", tick); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; up = 1'b0; load = 1'b0; one_shot = 1'b0;
    load_value = '0; final_value = '0;
    cyc();
    reset = 1'b0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_one_shot();
    test_halt_exit();
    test_out_of_range();
    test_hold_priority();
    test_final_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_mod_counter.md
PROG_MOD_COUNTER -- requirements
Module: prog_mod_counter

Interface
REQ-001 Parameter: BITS, default 4, counter and limit width in bits (BITS >= 2).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 enable  input  1  count enable; when 0, Q holds.
REQ-005 up  input  1  direction: 1 = count up, 0 = count down.
REQ-006 load  input  1  synchronous load request.
REQ-007 load_value  input  BITS  value written to Q on load.
REQ-008 FINAL_VALUE  input  BITS  modulus limit: the sequence runs 0..FINAL_VALUE inclusive; may change at any time.
REQ-009 one_shot  input  1  mode: 1 = stop at terminal count, 0 = wrap.
REQ-010 Q  output  BITS  registered count.
REQ-011 done  output  1  combinational terminal-count flag.
REQ-012 tick  output  1  combinational one-cycle cascade pulse.
REQ-013 halted  output  1  registered; 1 while the counter is stopped in one-shot mode.

Function
REQ-014 done SHALL be (Q >= FINAL_VALUE) when up=1, and (Q == 0) when up=0.
REQ-015 The block SHALL have two states, COUNT and HALT; halted SHALL be 1 exactly in HALT.
REQ-016 Update priority each edge SHALL be: reset, then load, then HALT hold, then enable, then hold.
REQ-017 load=1 SHALL write load_value to Q and enter COUNT, regardless of state, enable, up or one_shot.
REQ-018 In COUNT with enable=1, up=1, done=0: Q SHALL increment by 1.
REQ-019 In COUNT with enable=1, up=1, done=1, one_shot=0: Q SHALL become 0, including when Q > FINAL_VALUE.
REQ-020 In COUNT with enable=1, up=0, done=0: Q SHALL decrement by 1, including when Q > FINAL_VALUE.
REQ-021 In COUNT with enable=1, up=0, done=1, one_shot=0: Q SHALL become FINAL_VALUE.
REQ-022 In COUNT with enable=1, done=1, one_shot=1: Q SHALL hold and the state SHALL move to HALT.
REQ-023 In HALT, Q SHALL hold regardless of enable or up.
REQ-024 HALT SHALL exit to COUNT on load=1, or on one_shot=0 (Q unchanged on that edge).
REQ-025 tick SHALL be enable & done & (state == COUNT) & ~load; it is therefore high for exactly one enabled cycle per wrap or halt.
REQ-026 Direction, FINAL_VALUE and one_shot changes SHALL take effect on the next edge with no extra latency.
REQ-027 With FINAL_VALUE=0, Q SHALL stay at 0 and tick SHALL equal enable in COUNT.
REQ-028 All arithmetic SHALL be modulo 2^BITS; no out-of-range value SHALL cause a hang.

Reset
REQ-029 reset=1 at an edge SHALL set Q=0 and state=COUNT (halted=0), overriding load and enable.
REQ-030 After reset, tick and done SHALL follow REQ-014/REQ-025 from Q=0 with no extra latency.
REQ-031 Reset asserted mid-count or in HALT SHALL take effect on the same edge.

Verification
REQ-032 Reset: Q=7, halted=1, load=1, reset=1 -> next edge Q=0, halted=0.
REQ-033 Up wrap: BITS=4, FINAL_VALUE=9, up=1, enable=1, one_shot=0 -> Q 0,1..9,0,1; tick high only while Q=9.
REQ-034 Down wrap: FINAL_VALUE=5, up=0, enable=1, from Q=0 -> Q 0,5,4,3,2,1,0,5; tick high only while Q=0.
REQ-035 One-shot: FINAL_VALUE=3, up=1, one_shot=1, enable held high -> Q 0,1,2,3,3,3; halted=1 from the edge after Q first reaches 3; one tick only. Then load=1, load_value=1 -> Q=1, halted=0.
REQ-036 Out-of-range load: FINAL_VALUE=9, load_value=12, up=1 -> Q=12, done=1, tick=1; next enabled edge Q=0. Same load with up=0 -> Q 12,11,10,9,8.
REQ-037 Hold and priority: enable=0 for 3 cycles at Q=4 -> Q stays 4, tick=0. load=1 and enable=1 at Q=4, load_value=2 -> Q=2.
